// File: rtl/mem_boot_arbiter_pkg.sv
// Shared types and default sizing for the boot sequencer / memory-port arbiter.
package mem_boot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_HOLD_CYCLES = 7;

endpackage

// File: rtl/mem_boot_arbiter_if.sv
// Bundle of loader, processor, host and memory-port signals around the arbiter.
interface mem_boot_arbiter_if
  import mem_boot_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              boot_start;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              cpu_reset;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_re;
  logic              cpu_we;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              boot_done;
  logic [ADDR_W:0]   load_count;

  // Arbiter side
  modport slave (
    input  boot_start, ld_valid, ld_addr, ld_data, ld_last,
    input  cpu_addr, cpu_wdata, cpu_re, cpu_we,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_dout,
    output ld_ready, cpu_reset, host_gnt, host_rvalid, host_rdata,
    output mem_we, mem_re, mem_addr, mem_din, boot_done, load_count
  );

  // Environment side: loader, processor, host and memory
  modport master (
    output boot_start, ld_valid, ld_addr, ld_data, ld_last,
    output cpu_addr, cpu_wdata, cpu_re, cpu_we,
    output host_req, host_we, host_addr, host_wdata,
    output mem_dout,
    input  ld_ready, cpu_reset, host_gnt, host_rvalid, host_rdata,
    input  mem_we, mem_re, mem_addr, mem_din, boot_done, load_count
  );

endinterface

// File: rtl/mem_boot_arbiter_mem_port_mux.sv
// Combinational steering of loader, processor or host onto the single memory port.
module mem_port_mux
  import mem_boot_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  state_t            i_state,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  input  logic              i_cpu_re,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_host_gnt,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_din
);

  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_re   = 1'b0;
    o_mem_addr = '0;
    o_mem_din  = '0;
    unique case (i_state)
      LOAD: begin
        if (i_ld_valid) begin
          o_mem_we   = 1'b1;
          o_mem_addr = i_ld_addr;
          o_mem_din  = i_ld_data;
        end
      end
      RUN: begin
        // The grant already excludes any cycle the processor uses the port
        if (i_host_gnt) begin
          o_mem_we   = i_host_we;
          o_mem_re   = ~i_host_we;
          o_mem_addr = i_host_addr;
          o_mem_din  = i_host_wdata;
        end else begin
          o_mem_we   = i_cpu_we;
          o_mem_re   = i_cpu_re;
          o_mem_addr = i_cpu_addr;
          o_mem_din  = i_cpu_wdata;
        end
      end
      default: begin
        o_mem_we = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_boot_arbiter.sv
// Boot sequencer (load, hold processor in reset, release) and run-time
// fixed-priority arbiter of the memory port between processor and host.
module mem_boot_arbiter
  import mem_boot_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  mem_boot_arbiter_if.slave bus
);

  localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  state_t              w_next;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [ADDR_W:0]     r_load_count;
  logic                r_host_rvalid;
  logic [DATA_W-1:0]   r_rdata_hold;

  logic w_ld_fire;
  logic w_host_gnt;
  logic w_hold_done;
  logic w_start_load;
  logic w_cpu_reset;
  logic w_ld_ready;
  logic w_boot_done;

  // Word counter stops at a full address space so it never wraps to zero
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == COUNT_MAX) ? v : v + (ADDR_W+1)'(1);
  endfunction

  always_comb begin
    w_ld_fire    = (r_state == LOAD) && bus.ld_valid;
    w_host_gnt   = (r_state == RUN) && bus.host_req && !bus.cpu_re && !bus.cpu_we;
    w_hold_done  = (r_state == HOLD) && (r_hold_cnt == HOLD_LAST);
    w_start_load = bus.boot_start && ((r_state == IDLE) || (r_state == RUN));
  end

  always_comb begin
    w_next      = r_state;
    w_cpu_reset = 1'b1;
    w_ld_ready  = 1'b0;
    w_boot_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.boot_start) w_next = LOAD;
      end
      LOAD: begin
        w_ld_ready = 1'b1;
        if (w_ld_fire && bus.ld_last) w_next = HOLD;
      end
      HOLD: begin
        if (w_hold_done) w_next = RUN;
      end
      RUN: begin
        w_cpu_reset = 1'b0;
        w_boot_done = 1'b1;
        if (bus.boot_start) w_next = LOAD;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_hold_cnt    <= '0;
      r_load_count  <= '0;
      r_host_rvalid <= 1'b0;
      r_rdata_hold  <= '0;
    end else begin
      r_state    <= w_next;
      r_hold_cnt <= ((r_state == HOLD) && !w_hold_done) ? r_hold_cnt + HOLD_W'(1) : '0;
      if (w_start_load) begin
        r_load_count <= '0;
      end else if (w_ld_fire) begin
        r_load_count <= sat_inc(r_load_count);
      end
      r_host_rvalid <= w_host_gnt && !bus.host_we;
      // Memory read data is live only in the rvalid cycle; keep it afterwards
      if (r_host_rvalid) begin
        r_rdata_hold <= bus.mem_dout;
      end
    end
  end

  mem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_port_mux (
    .i_state      (r_state),
    .i_ld_valid   (bus.ld_valid),
    .i_ld_addr    (bus.ld_addr),
    .i_ld_data    (bus.ld_data),
    .i_cpu_re     (bus.cpu_re),
    .i_cpu_we     (bus.cpu_we),
    .i_cpu_addr   (bus.cpu_addr),
    .i_cpu_wdata  (bus.cpu_wdata),
    .i_host_gnt   (w_host_gnt),
    .i_host_we    (bus.host_we),
    .i_host_addr  (bus.host_addr),
    .i_host_wdata (bus.host_wdata),
    .o_mem_we     (bus.mem_we),
    .o_mem_re     (bus.mem_re),
    .o_mem_addr   (bus.mem_addr),
    .o_mem_din    (bus.mem_din)
  );

  assign bus.ld_ready    = w_ld_ready;
  assign bus.cpu_reset   = w_cpu_reset;
  assign bus.boot_done   = w_boot_done;
  assign bus.host_gnt    = w_host_gnt;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.host_rdata  = r_host_rvalid ? bus.mem_dout : r_rdata_hold;
  assign bus.load_count  = r_load_count;

endmodule

// File: tb/tb_mem_boot_arbiter.sv
// Randomized bench: a memory model, a scoreboard of expected memory writes and
// host read returns, and a monitor that checks them on every falling edge.
module tb_mem_boot_arbiter;
  import mem_boot_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int HC = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  mem_boot_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_boot_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(HC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  bit [DW-1:0] mem     [1<<AW];
  bit [DW-1:0] ref_mem [1<<AW];

  typedef struct {
    int          t;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  ev_t           wq[$];
  ev_t           rq[$];
  ev_t           w_ev;
  ev_t           r_ev;
  logic [DW-1:0] last_rd = '0;
  bit            w_exp;
  bit            r_exp;

  // Single-port memory with registered read data
  always @(posedge clock) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
    if (bus.mem_re) bus.mem_dout <= mem[bus.mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: memory writes and host read returns must match the queues cycle by cycle
  always @(negedge clock) begin
    if (!reset) begin
      last_rd = '0;
    end else begin
      w_exp = (wq.size() > 0) && (wq[0].t == cyc);
      chk("mem_we", 32'(bus.mem_we), 32'(w_exp));
      if (w_exp) begin
        w_ev = wq.pop_front();
        chk("mem_addr", 32'(bus.mem_addr), 32'(w_ev.a));
        chk("mem_din", 32'(bus.mem_din), 32'(w_ev.d));
      end
      r_exp = (rq.size() > 0) && (rq[0].t == cyc);
      chk("host_rvalid", 32'(bus.host_rvalid), 32'(r_exp));
      if (r_exp) begin
        r_ev    = rq.pop_front();
        last_rd = r_ev.d;
      end
      chk("host_rdata", 32'(bus.host_rdata), 32'(last_rd));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    bus.boot_start = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_last    = 1'b0;
    bus.cpu_re     = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.host_req   = 1'b0;
  endtask

  task automatic junk();
    bus.cpu_re     = 1'($urandom);
    bus.cpu_we     = 1'($urandom);
    bus.cpu_addr   = AW'($urandom);
    bus.cpu_wdata  = DW'($urandom);
    bus.host_req   = 1'($urandom);
    bus.host_we    = 1'($urandom);
    bus.host_addr  = AW'($urandom);
    bus.host_wdata = DW'($urandom);
  endtask

  // Pulse boot_start, stream n words (base<0: random addresses), check hold and release
  task automatic boot(input int n, input int base, input int gap_at, input int abort_at);
    int            cnt = 0;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    quiet();
    bus.boot_start = 1'b1;
    step();
    bus.boot_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < 3; g++) begin
          junk();
          bus.ld_valid   = 1'b0;
          bus.boot_start = 1'b0;
          @(negedge clock);
          chk("gap_ld_ready", 32'(bus.ld_ready), 32'd1);
          chk("gap_host_gnt", 32'(bus.host_gnt), 32'd0);
          step();
        end
      end
      a = (base < 0) ? AW'($urandom) : AW'(base + i);
      d = DW'($urandom);
      junk();
      bus.ld_valid   = 1'b1;
      bus.ld_addr    = a;
      bus.ld_data    = d;
      bus.ld_last    = (i == n - 1);
      bus.boot_start = (i == 1);
      wq.push_back('{t: cyc, a: a, d: d});
      ref_mem[a] = d;
      @(negedge clock);
      chk("load_ld_ready", 32'(bus.ld_ready), 32'd1);
      chk("load_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      chk("load_count", 32'(bus.load_count), cnt);
      chk("load_host_gnt", 32'(bus.host_gnt), 32'd0);
      if (cnt < (1 << AW)) cnt++;
      step();
    end
    bus.ld_valid   = 1'b0;
    bus.ld_last    = 1'b0;
    bus.boot_start = 1'b0;
    for (int k = 0; k < HC; k++) begin
      junk();
      if (k == abort_at) begin
        reset = 1'b0;
        step();
        quiet();
        bus.host_req = 1'b1;
        @(negedge clock);
        chk("abort_cpu_reset", 32'(bus.cpu_reset), 32'd1);
        chk("abort_boot_done", 32'(bus.boot_done), 32'd0);
        chk("abort_load_count", 32'(bus.load_count), 32'd0);
        chk("abort_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("abort_host_gnt", 32'(bus.host_gnt), 32'd0);
        chk("abort_rvalid", 32'(bus.host_rvalid), 32'd0);
        reset = 1'b1;
        step();
        quiet();
        return;
      end
      @(negedge clock);
      chk("hold_cpu_reset", 32'(bus.cpu_reset), 32'd1);
      chk("hold_boot_done", 32'(bus.boot_done), 32'd0);
      chk("hold_ld_ready", 32'(bus.ld_ready), 32'd0);
      chk("hold_load_count", 32'(bus.load_count), cnt);
      chk("hold_host_gnt", 32'(bus.host_gnt), 32'd0);
      step();
    end
    quiet();
    @(negedge clock);
    chk("run_cpu_reset", 32'(bus.cpu_reset), 32'd0);
    chk("run_boot_done", 32'(bus.boot_done), 32'd1);
    chk("run_load_count", 32'(bus.load_count), cnt);
    step();
  endtask

  // One RUN cycle: processor has priority, host is granted only on an idle processor cycle
  task automatic run_cycle(input bit cre, input bit cwe, input logic [AW-1:0] ca,
                           input logic [DW-1:0] cd, input bit hreq, input bit hwe,
                           input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                           output bit granted);
    bus.cpu_re     = cre;
    bus.cpu_we     = cwe;
    bus.cpu_addr   = ca;
    bus.cpu_wdata  = cd;
    bus.host_req   = hreq;
    bus.host_we    = hwe;
    bus.host_addr  = ha;
    bus.host_wdata = hd;
    granted = hreq && !cre && !cwe;
    if (cwe) begin
      wq.push_back('{t: cyc, a: ca, d: cd});
      ref_mem[ca] = cd;
    end
    if (granted) begin
      if (hwe) begin
        wq.push_back('{t: cyc, a: ha, d: hd});
        ref_mem[ha] = hd;
      end else begin
        rq.push_back('{t: cyc + 1, a: ha, d: ref_mem[ha]});
      end
    end
    @(negedge clock);
    chk("run_host_gnt", 32'(bus.host_gnt), 32'(granted));
    chk("run_mem_re", 32'(bus.mem_re), 32'(cre || (granted && !hwe)));
    chk("run_boot_done", 32'(bus.boot_done), 32'd1);
    step();
  endtask

  task automatic run_random(input int cycles);
    bit            pend = 1'b0;
    bit            hwe  = 1'b0;
    bit            g;
    logic [AW-1:0] ha = '0;
    logic [DW-1:0] hd = '0;
    int            act;
    for (int c = 0; c < cycles; c++) begin
      if (!pend && ($urandom_range(0, 2) == 0)) begin
        pend = 1'b1;
        hwe  = 1'($urandom);
        ha   = AW'($urandom_range(0, 31));
        hd   = DW'($urandom);
      end
      act = $urandom_range(0, 3);
      run_cycle(act == 0, act == 1, AW'($urandom_range(0, 31)), DW'($urandom),
                pend, hwe, ha, hd, g);
      if (g) pend = 1'b0;
    end
    quiet();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    quiet();
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    reset = 1'b0;
    repeat (2) step();
    bus.host_req = 1'b1;
    bus.cpu_we   = 1'b1;
    @(negedge clock);
    chk("rst_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
    chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    chk("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
    chk("rst_boot_done", 32'(bus.boot_done), 32'd0);
    chk("rst_load_count", 32'(bus.load_count), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    reset = 1'b1;
    step();
    @(negedge clock);
    chk("idle_cpu_reset", 32'(bus.cpu_reset), 32'd1);
    chk("idle_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("idle_host_gnt", 32'(bus.host_gnt), 32'd0);
    chk("idle_boot_done", 32'(bus.boot_done), 32'd0);
    step();

    boot(17, 0, -1, -1);

    run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h0A, '0, g);
    run_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, g);

    run_cycle(1'b0, 1'b1, 8'h14, 16'hA5A5, 1'b1, 1'b1, 8'h15, 16'h5A5A, g);
    run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h15, 16'h5A5A, g);
    run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h14, '0, g);
    run_cycle(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h15, '0, g);
    run_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, g);

    run_random(300);
    boot(6, 8'h40, 3, -1);
    run_random(100);
    boot(2, 8'h80, -1, -1);
    run_random(50);
    boot(5, 8'h90, -1, 3);
    boot(258, -1, -1, -1);
    run_random(200);

    repeat (2) step();
    chk("wq_drained", wq.size(), 32'd0);
    chk("rq_drained", rq.size(), 32'd0);
    for (int a = 0; a < (1 << AW); a++) begin
      chk("mem_image", 32'(mem[a]), 32'(ref_mem[a]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_boot_arbiter.md
# mem_boot_arbiter

Owns the single port of the program/data memory. It sequences boot: it streams loader words into memory while the processor is held in reset, holds reset for a fixed number of cycles, then releases the processor. At run time it arbitrates the memory port between the processor (fixed priority) and a host/debug requester. It sits between the processor, the memory and the loader/host side, and replaces the ad-hoc preload mux.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 16, memory word width
- HOLD_CYCLES, 7, cycles processor reset stays high after last load write (≥1)

Ports:
- clock  in  1  system clock; everything samples on rising edge
- reset  in  1  synchronous, active-low block reset
- boot_start  in  1  one-cycle pulse; begins a load from IDLE or RUN
- ld_valid  in  1  loader word valid
- ld_ready  out  1  block accepts loader word
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_last  in  1  marks final loader word
- cpu_reset  out  1  active-high reset to processor
- cpu_addr  in  ADDR_W  processor memory address
- cpu_wdata  in  DATA_W  processor write data
- cpu_re  in  1  processor read request
- cpu_we  in  1  processor write request
- host_req  in  1  host access request, held until granted
- host_we  in  1  host write (1) / read (0)
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  DATA_W  host read data
- mem_we, mem_re  out  1  memory strobes
- mem_addr  out  ADDR_W; mem_din  out  DATA_W; mem_dout  in  DATA_W (registered, 1-cycle read latency)
- boot_done  out  1  high in RUN
- load_count  out  ADDR_W+1  words written in current/last load

## Operation
- States: IDLE, LOAD, HOLD, RUN; state register only, outputs decoded from state.
- IDLE: cpu_reset=1, ld_ready=0, memory strobes 0. boot_start → LOAD.
- LOAD: ld_ready=1. On ld_valid: mem_we=1, mem_addr=ld_addr, mem_din=ld_data, load_count+1 (saturates at 2^ADDR_W). Accepted with ld_last → HOLD. No ld_valid → strobes 0, stay.
- HOLD: cpu_reset=1, strobes 0, hold counter 0..HOLD_CYCLES-1; at HOLD_CYCLES-1 → RUN.
- RUN: cpu_reset=0, boot_done=1. Memory port passes cpu_addr/cpu_wdata/cpu_re/cpu_we through. host_gnt = host_req & ~cpu_re & ~cpu_we (combinational). When granted: mem_addr=host_addr, mem_we=host_we, mem_re=~host_we, mem_din=host_wdata.
- boot_start in RUN → LOAD; load_count cleared; cpu_reset high from the next cycle. boot_start in LOAD/HOLD is ignored.
- host_req outside RUN is never granted.
- cpu_re and cpu_we while cpu_reset=1 are ignored.

## Timing
- Reset (reset=0 at edge): state IDLE; cpu_reset=1; ld_ready=0; host_gnt=0; host_rvalid=0; host_rdata=0; boot_done=0; load_count=0; mem_we=mem_re=0; hold counter 0.
- Loader write is zero-latency: the memory captures the word on the same edge as the handshake. Throughput is 1 word/cycle.
- LOAD→HOLD on the edge accepting ld_last. cpu_reset stays high exactly HOLD_CYCLES cycles after that edge, then RUN.
- host_rvalid is registered: high the cycle after a granted host read. host_rdata equals mem_dout in that cycle and is held until the next rvalid.
- CPU access and host_req in the same cycle: CPU wins; host_gnt=0; host retries with request held.
- Reset asserted mid-LOAD or mid-HOLD: return to IDLE and drop the pending host_rvalid. Memory contents are untouched.

## Structure
- Package mem_boot_pkg: state enum (IDLE, LOAD, HOLD, RUN), default ADDR_W/DATA_W/HOLD_CYCLES constants.
- Single module plus one natural sub-module, mem_port_mux: combinational select of loader/CPU/host onto the memory port, driven by the state and the grant.

## Test plan
- Reset, then boot_start, then load 17 words (addr 0x00–0x10, last at 0x10): each word written the cycle it is accepted. load_count=17. cpu_reset high for 7 cycles after the last word, then 0, with boot_done=1.
- Loader gaps (ld_valid low 3 cycles mid-stream): no spurious mem_we. Memory image matches; final state RUN.
- RUN, host read 0x0A while CPU idle: host_gnt same cycle. Next cycle host_rvalid=1 and host_rdata = value stored at 0x0A.
- RUN, cpu_we to 0x14 and host write to 0x15 in the same cycle: CPU write happens, host_gnt=0. Host is granted the first cycle CPU strobes drop. Both locations hold the written values.
- reset driven low during HOLD cycle 3: next cycle IDLE, cpu_reset=1, boot_done=0, load_count=0.
- boot_start in RUN: LOAD next cycle, cpu_reset=1. Reload of 2 words then release after HOLD_CYCLES.
